l1d_writeback_buffer: RTL and testbench

Line-granular write-back buffer between the `l1_data_cache` lower-cache (LC) port and the lower cache. It absorbs dirty-line evictions so L1D read misses are not stalled behind write traffic. It forwards read misses that hit a buffered line directly from the buffer, and passes all other reads and responses through to the lower cache.

---
 rtl/l1d_wb_pkg.sv | 25 ++
 rtl/l1d_writeback_buffer.sv | 246 ++++++++++++++++++++++++
 tb/tb_l1d_writeback_buffer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1d_wb_pkg.sv
// Shared types and constants for the L1D write-back buffer.
//   LINE_BITS     : width of one cache line (64 bytes)
//   OFFSET_BITS   : byte offset bits inside a line
//   WB_PADDR_BITS : physical address width the entry struct is built for
//   wb_entry_t    : one write FIFO entry {valid, addr, data}
//   slot_state_e  : lower-cache request slot state
package l1d_wb_pkg;

    localparam int LINE_BITS     = 512;
    localparam int OFFSET_BITS   = 6;
    localparam int WB_PADDR_BITS = 22;

    typedef struct packed {
        logic                     valid;
        logic [WB_PADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } slot_state_e;

endpackage

// File: rtl/l1d_writeback_buffer.sv
// Line-granular write-back buffer between the L1D lower-cache port and the
// lower cache. Dirty-line evictions are parked in a small FIFO and drained in
// the background; read misses that hit a parked line are answered from the
// buffer, all other reads go to the lower cache ahead of pending writes.
//
// Ports
//   clk_in, rst_N_in            : clock, synchronous active-low reset
//   l1_valid_in/l1_ready_out    : L1D request (l1_we_in=1 eviction, 0 read),
//                                 l1_addr_in, l1_value_in
//   l1_valid_out/l1_ready_in    : fill response to L1D, l1_addr_out, l1_value_out
//   lc_valid_out/lc_ready_in    : request to lower cache, lc_addr_out,
//                                 lc_value_out, lc_we_out
//   lc_valid_in/lc_ready_out    : lower-cache response, lc_addr_in, lc_value_in
//   empty_out                   : nothing buffered and no write in flight
//   dbg_slot_state_out          : current request slot state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge; ready
// never depends on the valid of the same channel.
//
// PADDR_BITS and 8*B must equal WB_PADDR_BITS and LINE_BITS of the package,
// DEPTH must be a power of two (pointers wrap by overflow).
module l1d_writeback_buffer
    import l1d_wb_pkg::*;
#(
    parameter int PADDR_BITS = WB_PADDR_BITS,
    parameter int B          = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [8*B-1:0]        l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [8*B-1:0]        l1_value_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [8*B-1:0]        lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [8*B-1:0]        lc_value_in,
    output logic                  empty_out,
    output slot_state_e           dbg_slot_state_out
);

    localparam int OFF   = $clog2(B);
    localparam int LW    = 8 * B;
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    // ---------------- state ----------------
    wb_entry_t             fifo_q [DEPTH];
    ptr_t                  head_q, tail_q;
    cnt_t                  count_q;

    slot_state_e           slot_q, slot_d;
    logic [PADDR_BITS-1:0] slot_addr_q, slot_addr_d;
    logic [LW-1:0]         slot_data_q, slot_data_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [PADDR_BITS-1:0] resp_addr_q, resp_addr_d;
    logic [LW-1:0]         resp_data_q, resp_data_d;

    // Holds every ready low while in reset and for the reset cycle itself.
    logic                  up_q;

    // ---------------- combinational ----------------
    logic [PADDR_BITS-1:0] l1_line_addr, lc_line_addr;
    logic [DEPTH-1:0]      match_v;
    logic                  lc_fire, pop, slot_free, resp_free, lc_rsp_fire;
    logic                  wr_avail, load_wr, rd_hit, hit_ok, evict_ok;
    logic                  hit_accept, miss_accept, rd_accept;
    logic                  coalesce, evict_accept, push;
    ptr_t                  load_idx, hit_idx, coal_idx, scan_idx;
    logic                  unused_offset_bits;

    assign l1_line_addr = {l1_addr_in[PADDR_BITS-1:OFF], {OFF{1'b0}}};
    assign lc_line_addr = {lc_addr_in[PADDR_BITS-1:OFF], {OFF{1'b0}}};
    assign unused_offset_bits = ^{l1_addr_in[OFF-1:0], lc_addr_in[OFF-1:0]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_v[i] = fifo_q[i].valid &&
                         (fifo_q[i].addr[PADDR_BITS-1:OFF] == l1_addr_in[PADDR_BITS-1:OFF]);
        end
    end

    always_comb begin
        lc_fire     = (slot_q != IDLE) && lc_ready_in;
        pop         = (slot_q == WR) && lc_ready_in;
        slot_free   = (slot_q == IDLE) || lc_fire;
        resp_free   = !resp_valid_q || l1_ready_in;
        lc_rsp_fire = up_q && resp_free && lc_valid_in;

        // Entry the slot would copy this cycle: the head, or the next one
        // when the head is being popped by a write handshake right now.
        load_idx = pop ? head_q + ptr_t'(1) : head_q;
        wr_avail = pop ? (count_q > cnt_t'(1)) : (count_q != '0);

        // Newest match wins: scan oldest to newest, the last hit sticks.
        rd_hit   = 1'b0;
        hit_idx  = head_q;
        scan_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + ptr_t'(k);
            if (match_v[scan_idx]) begin
                rd_hit  = 1'b1;
                hit_idx = scan_idx;
            end
        end

        hit_ok      = resp_free && !lc_valid_in;
        hit_accept  = up_q && l1_valid_in && !l1_we_in && rd_hit && hit_ok;
        miss_accept = up_q && l1_valid_in && !l1_we_in && !rd_hit && slot_free;
        rd_accept   = hit_accept || miss_accept;
        load_wr     = slot_free && !rd_accept && wr_avail;

        // Only the head already owned by the slot is off limits; an entry
        // being copied this very cycle takes the new data via the slot.
        coalesce = 1'b0;
        coal_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_v[i] && !((slot_q == WR) && (ptr_t'(i) == head_q))) begin
                coalesce = 1'b1;
                coal_idx = ptr_t'(i);
            end
        end

        // A pop frees the head slot in the same edge, so a full FIFO can
        // still take a new entry then.
        evict_ok     = coalesce || (count_q != cnt_t'(DEPTH)) || pop;
        evict_accept = up_q && l1_valid_in && l1_we_in && evict_ok;
        push         = evict_accept && !coalesce;

        l1_ready_out = up_q && (l1_we_in ? evict_ok : (rd_hit ? hit_ok : slot_free));

        // Request slot next state
        slot_d      = slot_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        if (lc_fire) begin
            slot_d = IDLE;
        end
        if (miss_accept) begin
            slot_d      = RD;
            slot_addr_d = l1_line_addr;
        end else if (load_wr) begin
            slot_d      = WR;
            slot_addr_d = fifo_q[load_idx].addr;
            slot_data_d = (evict_accept && coalesce && (coal_idx == load_idx)) ?
                          l1_value_in : fifo_q[load_idx].data;
        end

        // Response register next state; lower-cache response has priority,
        // hit_accept is already blocked whenever lc_valid_in is high.
        resp_valid_d = resp_valid_q && !l1_ready_in;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        if (lc_rsp_fire) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = lc_line_addr;
            resp_data_d  = lc_value_in;
        end else if (hit_accept) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = l1_line_addr;
            resp_data_d  = fifo_q[hit_idx].data;
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            slot_q      <= IDLE;
            slot_addr_q <= '0;
            slot_data_q <= '0;
        end else begin
            slot_q      <= slot_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            up_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            up_q         <= 1'b1;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                fifo_q[head_q].valid <= 1'b0;
                head_q               <= head_q + ptr_t'(1);
            end
            if (evict_accept && coalesce) begin
                fifo_q[coal_idx].data <= l1_value_in;
            end
            // Placed after the pop so a full-FIFO push into the freed head wins.
            if (push) begin
                fifo_q[tail_q].valid <= 1'b1;
                fifo_q[tail_q].addr  <= l1_line_addr;
                fifo_q[tail_q].data  <= l1_value_in;
                tail_q               <= tail_q + ptr_t'(1);
            end
            count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // ---------------- outputs ----------------
    assign lc_valid_out       = (slot_q != IDLE);
    assign lc_we_out          = (slot_q == WR);
    assign lc_addr_out        = slot_addr_q;
    assign lc_value_out       = slot_data_q;
    assign lc_ready_out       = up_q && resp_free;
    assign l1_valid_out       = resp_valid_q;
    assign l1_addr_out        = resp_addr_q;
    assign l1_value_out       = resp_data_q;
    assign empty_out          = (count_q == '0) && (slot_q != WR);
    assign dbg_slot_state_out = slot_q;

endmodule

// File: tb/tb_l1d_writeback_buffer.sv
module tb_l1d_writeback_buffer;
    import l1d_wb_pkg::*;

    localparam int AW = 22;
    localparam int DW = 512;
    localparam int W  = AW + DW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic          l1_valid_in, l1_ready_out, l1_we_in;
    logic [AW-1:0] l1_addr_in;
    logic [DW-1:0] l1_value_in;
    logic          l1_valid_out, l1_ready_in;
    logic [AW-1:0] l1_addr_out;
    logic [DW-1:0] l1_value_out;
    logic          lc_valid_out, lc_ready_in, lc_we_out;
    logic [AW-1:0] lc_addr_out;
    logic [DW-1:0] lc_value_out;
    logic          lc_valid_in, lc_ready_out;
    logic [AW-1:0] lc_addr_in;
    logic [DW-1:0] lc_value_in;
    logic          empty_out;
    slot_state_e   dbg_state;

    l1d_writeback_buffer dut (
        .clk_in             (clk),
        .rst_N_in           (rst_n),
        .l1_valid_in        (l1_valid_in),
        .l1_ready_out       (l1_ready_out),
        .l1_addr_in         (l1_addr_in),
        .l1_value_in        (l1_value_in),
        .l1_we_in           (l1_we_in),
        .l1_valid_out       (l1_valid_out),
        .l1_ready_in        (l1_ready_in),
        .l1_addr_out        (l1_addr_out),
        .l1_value_out       (l1_value_out),
        .lc_valid_out       (lc_valid_out),
        .lc_ready_in        (lc_ready_in),
        .lc_addr_out        (lc_addr_out),
        .lc_value_out       (lc_value_out),
        .lc_we_out          (lc_we_out),
        .lc_valid_in        (lc_valid_in),
        .lc_ready_out       (lc_ready_out),
        .lc_addr_in         (lc_addr_in),
        .lc_value_in        (lc_value_in),
        .empty_out          (empty_out),
        .dbg_slot_state_out (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           wr_seen  = 0;
    int           rd_seen  = 0;
    logic [W-1:0] exp_q[$];   // expected LC writes {addr, data}, in order

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] s);
        return {16{s}};
    endfunction

    // Lower-cache handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && lc_valid_out && lc_ready_in) begin
            if (lc_we_out) begin
                wr_seen++;
                check_eq("lc_wr_queued", W'(exp_q.size() > 0), W'(1));
                if (exp_q.size() > 0) begin
                    check_eq("lc_wr_line", {lc_addr_out, lc_value_out}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end else begin
                rd_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n;
        n = 0;
        l1_valid_in = 1'b1;
        l1_we_in    = we;
        l1_addr_in  = addr;
        l1_value_in = data;
        #1;
        while (!l1_ready_out && n < 50) begin
            step();
            n++;
        end
        check_eq("req_accepted", W'(n < 50), W'(1));
        step();
        l1_valid_in = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!empty_out && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, W'(empty_out), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int rd_before, wr_before;
        rst_n = 1'b0;
        l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_addr_in = '0; l1_value_in = '0;
        l1_ready_in = 1'b0; lc_ready_in = 1'b0;
        lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
        step(); step();

        // Reset values
        check_eq("rst_l1_ready",  W'(l1_ready_out), W'(0));
        check_eq("rst_l1_valid",  W'(l1_valid_out), W'(0));
        check_eq("rst_lc_valid",  W'(lc_valid_out), W'(0));
        check_eq("rst_lc_we",     W'(lc_we_out), W'(0));
        check_eq("rst_lc_ready",  W'(lc_ready_out), W'(0));
        check_eq("rst_lc_line",   {lc_addr_out, lc_value_out}, W'(0));
        check_eq("rst_l1_line",   {l1_addr_out, l1_value_out}, W'(0));
        check_eq("rst_empty",     W'(empty_out), W'(1));
        rst_n = 1'b1;
        step();
        check_eq("up_lc_ready",   W'(lc_ready_out), W'(1));
        check_eq("up_l1_ready",   W'(l1_ready_out), W'(1));

        // 1: eviction then read of same line is answered from the buffer
        rd_before = rd_seen;
        do_req(1'b1, 22'h002000, mk(32'hAAAA_0001));
        check_eq("t1_not_empty", W'(empty_out), W'(0));
        do_req(1'b0, 22'h002010, '0);
        check_eq("t1_hit_valid", W'(l1_valid_out), W'(1));
        check_eq("t1_hit_line",  {l1_addr_out, l1_value_out}, {22'h002000, mk(32'hAAAA_0001)});
        l1_ready_in = 1'b1;
        step();
        l1_ready_in = 1'b0;
        check_eq("t1_resp_drained", W'(l1_valid_out), W'(0));
        exp_q.push_back({22'h002000, mk(32'hAAAA_0001)});
        lc_ready_in = 1'b1;
        wait_empty("t1_drain");
        lc_ready_in = 1'b0;
        check_eq("t1_no_lc_read", W'(rd_seen), W'(rd_before));

        // 2: back-to-back evictions to one line coalesce into one write
        wr_before = wr_seen;
        do_req(1'b1, 22'h004000, mk(32'h1111_0000));
        do_req(1'b1, 22'h004000, mk(32'h2222_0000));
        check_eq("t2_lc_valid", W'(lc_valid_out), W'(1));
        check_eq("t2_lc_we",    W'(lc_we_out), W'(1));
        check_eq("t2_lc_line",  {lc_addr_out, lc_value_out}, {22'h004000, mk(32'h2222_0000)});
        exp_q.push_back({22'h004000, mk(32'h2222_0000)});
        lc_ready_in = 1'b1;
        wait_empty("t2_drain");
        lc_ready_in = 1'b0;
        check_eq("t2_one_write", W'(wr_seen), W'(wr_before + 1));

        // 3: full boundary
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 22'h001000 + 22'(i * 64), mk(32'hD000_0000 + i));
        end
        l1_valid_in = 1'b1; l1_we_in = 1'b1;
        l1_addr_in  = 22'h001100; l1_value_in = mk(32'hD000_0004);
        #1;
        check_eq("t3_full_refused", W'(l1_ready_out), W'(0));
        check_eq("t3_full_not_empty", W'(empty_out), W'(0));
        l1_valid_in = 1'b0;
        do_req(1'b1, 22'h001040, mk(32'hD111_0001));
        exp_q.push_back({22'h001000, mk(32'hD000_0000)});
        exp_q.push_back({22'h001040, mk(32'hD111_0001)});
        exp_q.push_back({22'h001080, mk(32'hD000_0002)});
        exp_q.push_back({22'h0010C0, mk(32'hD000_0003)});
        exp_q.push_back({22'h001100, mk(32'hD000_0004)});
        l1_valid_in = 1'b1; l1_we_in = 1'b1;
        l1_addr_in  = 22'h001100; l1_value_in = mk(32'hD000_0004);
        lc_ready_in = 1'b1;
        #1;
        check_eq("t3_push_with_pop", W'(l1_ready_out), W'(1));
        step();
        l1_valid_in = 1'b0;
        lc_ready_in = 1'b0;
        l1_addr_in  = 22'h001140; l1_value_in = mk(32'hD000_0005);
        l1_valid_in = 1'b1;
        #1;
        check_eq("t3_still_full", W'(l1_ready_out), W'(0));
        l1_valid_in = 1'b0;
        lc_ready_in = 1'b1;
        wait_empty("t3_drain");
        lc_ready_in = 1'b0;
        check_eq("t3_all_written", W'(exp_q.size()), W'(0));

        // 4: read miss overtakes a pending write
        do_req(1'b1, 22'h005000, mk(32'h5555_5555));
        do_req(1'b0, 22'h060300, '0);
        check_eq("t4_rd_valid", W'(lc_valid_out), W'(1));
        check_eq("t4_rd_we",    W'(lc_we_out), W'(0));
        check_eq("t4_rd_addr",  W'(lc_addr_out), W'(22'h060300));
        check_eq("t4_rd_state", W'(dbg_state), W'(RD));
        check_eq("t4_not_empty", W'(empty_out), W'(0));
        exp_q.push_back({22'h005000, mk(32'h5555_5555)});
        rd_before = rd_seen;
        lc_ready_in = 1'b1;
        step();
        check_eq("t4_rd_done",    W'(rd_seen), W'(rd_before + 1));
        check_eq("t4_wr_next",    W'(lc_we_out & lc_valid_out), W'(1));
        check_eq("t4_empty_hold", W'(empty_out), W'(0));
        wait_empty("t4_drain");
        lc_ready_in = 1'b0;
        check_eq("t4_written", W'(exp_q.size()), W'(0));

        // 5: lower-cache response collides with a read hit
        do_req(1'b1, 22'h007000, mk(32'h7777_0007));
        step();
        l1_ready_in = 1'b1;
        lc_valid_in = 1'b1; lc_addr_in = 22'h060315; lc_value_in = DW'(32'hDEADBEEF);
        l1_valid_in = 1'b1; l1_we_in = 1'b0; l1_addr_in = 22'h007000;
        #1;
        check_eq("t5_hit_stalled", W'(l1_ready_out), W'(0));
        check_eq("t5_lc_ready",    W'(lc_ready_out), W'(1));
        step();
        lc_valid_in = 1'b0;
        check_eq("t5_rsp_valid", W'(l1_valid_out), W'(1));
        check_eq("t5_rsp_line",  {l1_addr_out, l1_value_out}, {22'h060300, DW'(32'hDEADBEEF)});
        #1;
        check_eq("t5_hit_now_ok", W'(l1_ready_out), W'(1));
        step();
        l1_valid_in = 1'b0;
        check_eq("t5_hit_valid", W'(l1_valid_out), W'(1));
        check_eq("t5_hit_line",  {l1_addr_out, l1_value_out}, {22'h007000, mk(32'h7777_0007)});
        step();
        l1_ready_in = 1'b0;
        check_eq("t5_resp_drained", W'(l1_valid_out), W'(0));
        exp_q.push_back({22'h007000, mk(32'h7777_0007)});
        lc_ready_in = 1'b1;
        wait_empty("t5_drain");
        lc_ready_in = 1'b0;

        // 6: eviction latency, then reset discards buffered writes
        do_req(1'b1, 22'h008000, mk(32'h8888_0000));
        check_eq("t6_lat_n1", W'(lc_valid_out), W'(0));
        step();
        check_eq("t6_lat_n2", W'(lc_valid_out & lc_we_out), W'(1));
        do_req(1'b1, 22'h008040, mk(32'h8888_0001));
        do_req(1'b1, 22'h008080, mk(32'h8888_0002));
        check_eq("t6_pre_rst_busy", W'(empty_out), W'(0));
        wr_before = wr_seen;
        rst_n = 1'b0;
        step();
        check_eq("t6_rst_empty",    W'(empty_out), W'(1));
        check_eq("t6_rst_lc_valid", W'(lc_valid_out), W'(0));
        check_eq("t6_rst_l1_valid", W'(l1_valid_out), W'(0));
        check_eq("t6_rst_l1_ready", W'(l1_ready_out), W'(0));
        rst_n = 1'b1;
        lc_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) step();
        lc_ready_in = 1'b0;
        check_eq("t6_no_writes",   W'(wr_seen), W'(wr_before));
        check_eq("t6_still_empty", W'(empty_out), W'(1));
        check_eq("t6_ready_back",  W'(l1_ready_out), W'(1));

        check_eq("final_exp_q_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
